// File: rtl/dmem_rt_initiator_if.sv
// Bundle of the host command, store, load, status and router signals of
// dmem_rt_initiator.
//   slave  : the initiator's view (I_* in, O_* out).
//   master : the environment's view (I_* driven, O_* observed).
// Handshake rule for every valid/ready pair (I_Cmd_Valid/O_Cmd_Ready,
// I_St_Valid/O_St_Ready): a transfer happens on the rising clock edge at
// which valid and ready are both 1. Ready never depends combinationally on
// valid. The router link (O_Rt_Req/I_Rt_Req) has no backpressure: every
// cycle with Req=1 carries one flit.
interface dmem_rt_initiator_if #(
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_ADDR = 16
);
  logic                  I_Cmd_Valid;
  logic                  I_Cmd_Is_St;
  logic [WIDTH_ADDR-1:0] I_Cmd_Length;
  logic [WIDTH_ADDR-1:0] I_Cmd_Stride;
  logic [WIDTH_ADDR-1:0] I_Cmd_Base;
  logic                  O_Cmd_Ready;
  logic                  I_St_Valid;
  logic [WIDTH_DATA-1:0] I_St_Data;
  logic                  O_St_Ready;
  logic                  O_Ld_Valid;
  logic [WIDTH_DATA-1:0] O_Ld_Data;
  logic                  O_Done;
  logic                  O_Short;
  logic                  O_Drop;
  logic                  O_Rt_Req;
  logic [WIDTH_DATA-1:0] O_Rt_Data;
  logic                  O_Rt_Rls;
  logic                  I_Rt_Req;
  logic [WIDTH_DATA-1:0] I_Rt_Data;
  logic                  I_Rt_Rls;

  modport slave (
    input  I_Cmd_Valid, I_Cmd_Is_St, I_Cmd_Length, I_Cmd_Stride, I_Cmd_Base,
    output O_Cmd_Ready,
    input  I_St_Valid, I_St_Data,
    output O_St_Ready,
    output O_Ld_Valid, O_Ld_Data,
    output O_Done, O_Short, O_Drop,
    output O_Rt_Req, O_Rt_Data, O_Rt_Rls,
    input  I_Rt_Req, I_Rt_Data, I_Rt_Rls
  );

  modport master (
    output I_Cmd_Valid, I_Cmd_Is_St, I_Cmd_Length, I_Cmd_Stride, I_Cmd_Base,
    input  O_Cmd_Ready,
    output I_St_Valid, I_St_Data,
    input  O_St_Ready,
    input  O_Ld_Valid, O_Ld_Data,
    input  O_Done, O_Short, O_Drop,
    input  O_Rt_Req, O_Rt_Data, O_Rt_Rls,
    output I_Rt_Req, I_Rt_Data, I_Rt_Rls
  );
endinterface

// File: rtl/dmem_rt_initiator.sv
// Data-memory router initiator. Accepts one host command (load or store),
// sends a four-flit header (kind, length, stride, base) toward data memory,
// then either forwards store beats as flits or collects returning load
// flits, and finishes with a one-cycle O_Done pulse.
// Ports:
//   clock        single clock, rising edge
//   reset        asynchronous, active-high
//   bus          dmem_rt_initiator_if.slave: command, store, load, status
//                and router signals
//   O_Dbg_State  current FSM state encoding (debug/observability only)
module dmem_rt_initiator #(
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_ADDR = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  dmem_rt_initiator_if.slave     bus,
  output logic [2:0]             O_Dbg_State
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_ST_DATA = 3'd2,
    S_LD_WAIT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            hdr_q, hdr_d;
  logic [WIDTH_ADDR-1:0] beat_q, beat_d;
  logic                  is_st_q, is_st_d;
  logic [WIDTH_ADDR-1:0] len_q, len_d;
  logic [WIDTH_ADDR-1:0] stride_q, stride_d;
  logic [WIDTH_ADDR-1:0] base_q, base_d;
  logic                  rt_req_q, rt_req_d;
  logic [WIDTH_DATA-1:0] rt_data_q, rt_data_d;
  logic                  rt_rls_q, rt_rls_d;
  logic                  ld_valid_q, ld_valid_d;
  logic [WIDTH_DATA-1:0] ld_data_q, ld_data_d;
  logic                  short_q, short_d;
  logic                  drop_q, drop_d;

  // Beat counts compared one bit wider so counter+1 cannot wrap.
  logic [WIDTH_ADDR:0]   beat_inc;
  logic [WIDTH_ADDR:0]   beat_now;
  logic [WIDTH_ADDR:0]   len_ext;

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    beat_d     = beat_q;
    is_st_d    = is_st_q;
    len_d      = len_q;
    stride_d   = stride_q;
    base_d     = base_q;
    short_d    = short_q;
    rt_req_d   = 1'b0;
    rt_data_d  = '0;
    rt_rls_d   = 1'b0;
    ld_valid_d = 1'b0;
    ld_data_d  = '0;
    drop_d     = drop_q | (bus.I_Rt_Req & (state_q != S_LD_WAIT));
    beat_inc   = {1'b0, beat_q} + 1'b1;
    len_ext    = {1'b0, len_q};
    beat_now   = bus.I_Rt_Req ? beat_inc : {1'b0, beat_q};

    case (state_q)
      S_IDLE: begin
        if (bus.I_Cmd_Valid) begin
          is_st_d   = bus.I_Cmd_Is_St;
          len_d     = bus.I_Cmd_Length;
          stride_d  = bus.I_Cmd_Stride;
          base_d    = bus.I_Cmd_Base;
          hdr_d     = 2'd0;
          beat_d    = '0;
          short_d   = 1'b0;
          // flit0 is registered on the accepting edge so it is on the wire
          // the very next cycle.
          rt_req_d  = 1'b1;
          rt_data_d = WIDTH_DATA'(bus.I_Cmd_Is_St);
          state_d   = S_HDR;
        end
      end

      S_HDR: begin
        hdr_d = hdr_q + 2'd1;
        case (hdr_q)
          2'd0: begin
            rt_req_d  = 1'b1;
            rt_data_d = WIDTH_DATA'(len_q);
          end
          2'd1: begin
            rt_req_d  = 1'b1;
            rt_data_d = WIDTH_DATA'(stride_q);
          end
          2'd2: begin
            rt_req_d  = 1'b1;
            rt_data_d = WIDTH_DATA'(base_q);
            // A load releases the link after its header; so does an empty
            // store, which has no data flit to carry the token.
            rt_rls_d  = ~is_st_q | (len_q == '0);
            // With data to move, the data phase overlaps the cycle flit3 is
            // on the wire; an empty transfer spends that cycle here instead.
            if (len_q != '0) begin
              beat_d  = '0;
              state_d = is_st_q ? S_ST_DATA : S_LD_WAIT;
            end
          end
          default: begin
            state_d = S_DONE;
          end
        endcase
      end

      S_ST_DATA: begin
        if (bus.I_St_Valid) begin
          rt_req_d  = 1'b1;
          rt_data_d = bus.I_St_Data;
          beat_d    = beat_inc[WIDTH_ADDR-1:0];
          if (beat_inc == len_ext) begin
            rt_rls_d = 1'b1;
            state_d  = S_DONE;
          end
        end
      end

      S_LD_WAIT: begin
        if (bus.I_Rt_Req) begin
          ld_valid_d = 1'b1;
          ld_data_d  = bus.I_Rt_Data;
          beat_d     = beat_inc[WIDTH_ADDR-1:0];
        end
        // The flit arriving with a release is counted before deciding
        // whether the load came up short.
        if (beat_now == len_ext) begin
          short_d = 1'b0;
          state_d = S_DONE;
        end else if (bus.I_Rt_Rls) begin
          short_d = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hdr_q      <= 2'd0;
      beat_q     <= '0;
      is_st_q    <= 1'b0;
      len_q      <= '0;
      stride_q   <= '0;
      base_q     <= '0;
      rt_req_q   <= 1'b0;
      rt_data_q  <= '0;
      rt_rls_q   <= 1'b0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
      short_q    <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      beat_q     <= beat_d;
      is_st_q    <= is_st_d;
      len_q      <= len_d;
      stride_q   <= stride_d;
      base_q     <= base_d;
      rt_req_q   <= rt_req_d;
      rt_data_q  <= rt_data_d;
      rt_rls_q   <= rt_rls_d;
      ld_valid_q <= ld_valid_d;
      ld_data_q  <= ld_data_d;
      short_q    <= short_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.O_Cmd_Ready = (state_q == S_IDLE);
  assign bus.O_St_Ready  = (state_q == S_ST_DATA);
  assign bus.O_Done      = (state_q == S_DONE);
  assign bus.O_Short     = (state_q == S_DONE) & short_q;
  assign bus.O_Drop      = drop_q;
  assign bus.O_Ld_Valid  = ld_valid_q;
  assign bus.O_Ld_Data   = ld_data_q;
  assign bus.O_Rt_Req    = rt_req_q;
  assign bus.O_Rt_Data   = rt_data_q;
  assign bus.O_Rt_Rls    = rt_rls_q;
  assign O_Dbg_State     = state_q;

endmodule
